// File: rtl/stage_reg_ctx.sv
// Purpose: parametrised pipeline stage register with a nested-interrupt context stack.
// Latency: one cycle from in_* to out_*; ctx_full/ctx_empty decode ctx_level combinationally.
// Backpressure: stall holds the register; flush and interrupts override stall and always win.
module stage_reg_ctx #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 8,
  parameter int CTX_DEPTH = 4,
  localparam int DW       = $clog2(CTX_DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   int_detect,
  input  logic                   int_return,
  input  logic                   clr_err,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [DW-1:0]          ctx_level,
  output logic                   ctx_full,
  output logic                   ctx_empty,
  output logic                   ctx_ovf,
  output logic                   ctx_udf
);

  localparam int DATA_W  = LANES * WIDTH;
  localparam int ENTRY_W = DATA_W + 1;
  localparam int AW      = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_L = DW'(CTX_DEPTH);

  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               push, ovf_set, udf_set;
  logic               full, empty;
  logic [AW-1:0]      push_idx, pop_idx;

  // Each entry is {valid, lanes}; storage needs no reset since ctx_level gates every read.
  logic [ENTRY_W-1:0] stack_q [CTX_DEPTH];

  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign push_idx = AW'(level_q);
  assign pop_idx  = AW'(level_q - 1'b1);

  // Next-state: flush > int_detect > int_return > stall > load; counter never wraps.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    level_d = level_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (int_detect) begin
      data_d  = '0;
      valid_d = 1'b0;
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        push    = 1'b1;
        level_d = level_q + 1'b1;
      end
    end else if (int_return) begin
      if (empty) begin
        udf_set = 1'b1;
        data_d  = '0;
        valid_d = 1'b0;
      end else begin
        {valid_d, data_d} = stack_q[pop_idx];
        level_d           = level_q - 1'b1;
      end
    end else if (!stall) begin
      data_d  = in_data;
      valid_d = in_valid;
    end
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    udf_d = udf_set | (udf_q & ~clr_err);
  end

  // Stage register, depth counter and sticky error flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Context push captures the current outputs before they are bubbled.
  always_ff @(posedge Clk) begin
    if (push) begin
      stack_q[push_idx] <= {valid_q, data_q};
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ctx_level = level_q;
  assign ctx_full  = full;
  assign ctx_empty = empty;
  assign ctx_ovf   = ovf_q;
  assign ctx_udf   = udf_q;

endmodule

// File: doc/stage_reg_ctx.md
Name: stage_reg_ctx

Overview:
Parametrised pipeline stage register that generalises the fixed 8x32 stage register.
- Configurable lane count and lane width.
- Valid bit plus stall (hold).
- Nested-interrupt context stack of configurable depth, replacing the single-slot save/restore.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives stall/flush and the interrupt controller drives int_detect/int_return.

Parameters:
WIDTH, 32, bits per lane
LANES, 8, number of lanes carried by the stage
CTX_DEPTH, 4, interrupt context stack entries (>=1); each entry holds all lanes plus the valid bit
DW, $clog2(CTX_DEPTH+1), width of the depth counter (derived, not overridable)

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
flush  input  1  insert bubble, no context save
stall  input  1  hold current contents
int_detect  input  1  push current contents to context stack, insert bubble
int_return  input  1  pop top context into outputs
clr_err  input  1  synchronous clear of ctx_ovf/ctx_udf
in_valid  input  1  incoming stage valid
in_data  input  LANES*WIDTH  packed lanes; lane k = bits [k*WIDTH +: WIDTH]
out_valid  output  1  registered valid
out_data  output  LANES*WIDTH  registered lanes
ctx_level  output  DW  number of saved contexts
ctx_full  output  1  ctx_level == CTX_DEPTH
ctx_empty  output  1  ctx_level == 0
ctx_ovf  output  1  sticky: push attempted while full
ctx_udf  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (Rst_n low, asynchronous):
  - out_data=0, out_valid=0, ctx_level=0, ctx_ovf=0, ctx_udf=0.
  - Stack contents are don't-care.
  - Reset asserted mid-nesting discards all saved contexts.
- Per rising edge, priority (highest first): flush > int_detect > int_return > stall > load.
- flush: out_data=0, out_valid=0; stack untouched.
- int_detect, stack not full:
  - stack[ctx_level] <= {out_valid,out_data}; ctx_level+1.
  - out_data=0, out_valid=0.
- int_detect, stack full: no push, ctx_level unchanged, ctx_ovf<=1, outputs still zeroed.
- int_return, stack not empty: {out_valid,out_data} <= stack[ctx_level-1]; ctx_level-1. Strict LIFO.
- int_return, stack empty: ctx_udf<=1, out_data=0, out_valid=0, ctx_level stays 0.
- int_detect and int_return together: detect wins, return ignored (no pop).
- flush with either interrupt: flush wins; no push/pop, no flag change.
- stall with an interrupt: interrupt wins.
- stall alone: all outputs hold.
- Load: out_data<=in_data, out_valid<=in_valid.
- Latency: one cycle in->out. ctx_full/ctx_empty are combinational from ctx_level.
- Zeroed payload is all zeros regardless of lane count. in_data is ignored whenever out_valid is forced to 0.
- clr_err clears flags next edge. A same-cycle new error wins: flag stays 1.
- Counter arithmetic never wraps: saturates at 0 and CTX_DEPTH via the full/empty checks above.

Test Plan:
- Reset: Rst_n low mid-cycle with out_data=0xFFFF... -> outputs 0, ctx_empty=1 immediately, without a clock edge.
- Load/stall:
  - lane3=0x12345678, in_valid=1 -> out lane3=0x12345678, out_valid=1 next edge.
  - stall=1 for 3 cycles with new inputs -> outputs unchanged.
- Nested interrupts (CTX_DEPTH=2):
  - load A=0xA, detect; load B=0xB, detect -> ctx_full=1.
  - return -> out=0xB; return -> out=0xA, ctx_empty=1.
- Overflow/underflow (CTX_DEPTH=2, full):
  - detect -> ctx_ovf=1, ctx_level=2, outputs 0.
  - drain both, extra return -> ctx_udf=1, out_valid=0.
  - clr_err -> both flags 0.
- Priority:
  - flush+int_detect -> bubble, ctx_level unchanged.
  - int_detect+int_return -> push only.
  - stall+int_return -> pop occurs.
- Parametrisation: WIDTH=16, LANES=3 instance -> lane2 = in[47:32] propagates correctly, zero-bubble covers all 48 bits.
